// File: rtl/spu_pkg.sv
// Shared SPU types and constants for the RF/FWD stage and its neighbours.
// Big-endian bit numbering throughout, matching the SPU ISA manual.
package spu_pkg;

    typedef logic [0:127] qword_t;
    typedef logic [0:6]   reg_addr_t;
    typedef logic [0:10]  opcode_t;
    typedef logic [0:17]  imm_t;
    typedef logic [2:0]   fmt_t;

    localparam opcode_t OP_NOP  = 11'd0;
    localparam fmt_t    FMT_RR  = 3'd0;
    localparam fmt_t    FMT_RI7 = 3'd2;

    // RF -> EX bundle
    typedef struct packed {
        opcode_t   op;
        fmt_t      format;
        reg_addr_t rt_addr;
        imm_t      imm;
        logic      reg_write;
        qword_t    ra;
        qword_t    rb;
        qword_t    rc;
    } rf_ex_t;

    localparam rf_ex_t RF_NOP = '{
        op:     OP_NOP,
        format: FMT_RR,
        default: '0
    };

endpackage

// File: rtl/operand_sel.sv
// operand_sel: resolves one source operand from fwd taps, wb ports, table.
// Ports: addr, tbl (table value), wb0/wb1 en/addr/data, fwd_en/addr/data
//        (tap 0 youngest), result. Taps honoured only with REGFILE_FWD_EN.
module operand_sel
    import spu_pkg::*;
#(
    parameter int FWD_DEPTH = 4
) (
    input  reg_addr_t                 addr,
    input  qword_t                    tbl,
    input  logic                      wb0_en,
    input  reg_addr_t                 wb0_addr,
    input  qword_t                    wb0_data,
    input  logic                      wb1_en,
    input  reg_addr_t                 wb1_addr,
    input  qword_t                    wb1_data,
    input  logic      [FWD_DEPTH-1:0] fwd_en,
    input  reg_addr_t [FWD_DEPTH-1:0] fwd_addr,
    input  qword_t    [FWD_DEPTH-1:0] fwd_data,
    output qword_t                    result
);

`ifndef REGFILE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, fwd_addr, fwd_data};
`endif

    // Lowest priority applied first so later matches override.
    always_comb begin
        result = tbl;
        if (wb0_en && (wb0_addr == addr))
            result = wb0_data;
        if (wb1_en && (wb1_addr == addr))
            result = wb1_data;
`ifdef REGFILE_FWD_EN
        // Walk oldest to youngest: lowest-index match wins.
        for (int t = FWD_DEPTH - 1; t >= 0; t--) begin
            if (fwd_en[t] && (fwd_addr[t] == addr))
                result = fwd_data[t];
        end
`endif
    end

endmodule

// File: rtl/reg_file_fwd.sv
// reg_file_fwd: SPU RF/FWD stage, 128x128b table, two wb ports, 3 operand
// reads with bypass, one-cycle registered output. Macro: REGFILE_FWD_EN.
module reg_file_fwd
    import spu_pkg::*;
#(
    parameter int NUM_REGS  = 128,
    parameter int FWD_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  opcode_t                   in_op,
    input  fmt_t                      in_format,
    input  reg_addr_t                 in_ra_addr,
    input  reg_addr_t                 in_rb_addr,
    input  reg_addr_t                 in_rc_addr,
    input  reg_addr_t                 in_rt_addr,
    input  imm_t                      in_imm,
    input  logic                      in_reg_write,
    input  logic                      stall,
    input  logic                      flush,
    input  qword_t                    wb0_data,
    input  qword_t                    wb1_data,
    input  reg_addr_t                 wb0_addr,
    input  reg_addr_t                 wb1_addr,
    input  logic                      wb0_en,
    input  logic                      wb1_en,
    input  qword_t    [FWD_DEPTH-1:0] fwd_data,
    input  reg_addr_t [FWD_DEPTH-1:0] fwd_addr,
    input  logic      [FWD_DEPTH-1:0] fwd_en,
    output opcode_t                   op,
    output fmt_t                      format,
    output reg_addr_t                 rt_addr,
    output imm_t                      imm,
    output logic                      reg_write,
    output qword_t                    ra,
    output qword_t                    rb,
    output qword_t                    rc
);

    qword_t regs [NUM_REGS];
    qword_t ra_res, rb_res, rc_res;
    rf_ex_t q;

    // wb1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (wb0_en)
                regs[wb0_addr] <= wb0_data;
            if (wb1_en)
                regs[wb1_addr] <= wb1_data;
        end
    end

    operand_sel #(.FWD_DEPTH(FWD_DEPTH)) u_sel_ra (
        .addr     (in_ra_addr),
        .tbl      (regs[in_ra_addr]),
        .wb0_en   (wb0_en),
        .wb0_addr (wb0_addr),
        .wb0_data (wb0_data),
        .wb1_en   (wb1_en),
        .wb1_addr (wb1_addr),
        .wb1_data (wb1_data),
        .fwd_en   (fwd_en),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .result   (ra_res)
    );

    operand_sel #(.FWD_DEPTH(FWD_DEPTH)) u_sel_rb (
        .addr     (in_rb_addr),
        .tbl      (regs[in_rb_addr]),
        .wb0_en   (wb0_en),
        .wb0_addr (wb0_addr),
        .wb0_data (wb0_data),
        .wb1_en   (wb1_en),
        .wb1_addr (wb1_addr),
        .wb1_data (wb1_data),
        .fwd_en   (fwd_en),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .result   (rb_res)
    );

    operand_sel #(.FWD_DEPTH(FWD_DEPTH)) u_sel_rc (
        .addr     (in_rc_addr),
        .tbl      (regs[in_rc_addr]),
        .wb0_en   (wb0_en),
        .wb0_addr (wb0_addr),
        .wb0_data (wb0_data),
        .wb1_en   (wb1_en),
        .wb1_addr (wb1_addr),
        .wb1_data (wb1_data),
        .fwd_en   (fwd_en),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .result   (rc_res)
    );

    // Held operands are not refreshed by writebacks during stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RF_NOP;
        end else if (stall) begin
            q <= q;
        end else if (flush || !in_valid) begin
            q <= RF_NOP;
        end else begin
            q.op        <= in_op;
            q.format    <= in_format;
            q.rt_addr   <= in_rt_addr;
            q.imm       <= in_imm;
            q.reg_write <= in_reg_write;
            q.ra        <= ra_res;
            q.rb        <= rb_res;
            q.rc        <= rc_res;
        end
    end

    assign op        = q.op;
    assign format    = q.format;
    assign rt_addr   = q.rt_addr;
    assign imm       = q.imm;
    assign reg_write = q.reg_write;
    assign ra        = q.ra;
    assign rb        = q.rb;
    assign rc        = q.rc;

endmodule

// File: tb/tb_reg_file_fwd.sv
// Testbench for reg_file_fwd: vector table plus hand sequences for
// stall/flush/reset/forwarding, checked through an expectation queue.
module tb_reg_file_fwd;
    import spu_pkg::*;

    localparam int FWD_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic                      in_valid;
    opcode_t                   in_op;
    fmt_t                      in_format;
    reg_addr_t                 in_ra_addr, in_rb_addr, in_rc_addr;
    reg_addr_t                 in_rt_addr;
    imm_t                      in_imm;
    logic                      in_reg_write;
    logic                      stall, flush;
    qword_t                    wb0_data, wb1_data;
    reg_addr_t                 wb0_addr, wb1_addr;
    logic                      wb0_en, wb1_en;
    qword_t    [FWD_DEPTH-1:0] fwd_data;
    reg_addr_t [FWD_DEPTH-1:0] fwd_addr;
    logic      [FWD_DEPTH-1:0] fwd_en;
    opcode_t                   op;
    fmt_t                      format;
    reg_addr_t                 rt_addr;
    imm_t                      imm;
    logic                      reg_write;
    qword_t                    ra, rb, rc;

    reg_file_fwd #(.NUM_REGS(128), .FWD_DEPTH(FWD_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_format    (in_format),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_rc_addr   (in_rc_addr),
        .in_rt_addr   (in_rt_addr),
        .in_imm       (in_imm),
        .in_reg_write (in_reg_write),
        .stall        (stall),
        .flush        (flush),
        .wb0_data     (wb0_data),
        .wb1_data     (wb1_data),
        .wb0_addr     (wb0_addr),
        .wb1_addr     (wb1_addr),
        .wb0_en       (wb0_en),
        .wb1_en       (wb1_en),
        .fwd_data     (fwd_data),
        .fwd_addr     (fwd_addr),
        .fwd_en       (fwd_en),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .imm          (imm),
        .reg_write    (reg_write),
        .ra           (ra),
        .rb           (rb),
        .rc           (rc)
    );

    localparam qword_t Q5  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam qword_t QAA = {16{8'hAA}};
    localparam qword_t QBB = {16{8'hBB}};
    localparam qword_t QCC = {16{8'hCC}};
    localparam qword_t QDD = {16{8'hDD}};
    localparam qword_t QEE = {16{8'hEE}};
    localparam qword_t Q11 = {16{8'h11}};
    localparam qword_t Q22 = {16{8'h22}};
    localparam qword_t Q33 = {16{8'h33}};
    localparam qword_t Q44 = {16{8'h44}};
    localparam qword_t Q55 = {16{8'h55}};
    localparam qword_t Q66 = {16{8'h66}};

    typedef struct {
        logic      valid;
        opcode_t   op;
        fmt_t      fmt;
        reg_addr_t ra, rb, rc, rt;
        imm_t      imm;
        logic      rw;
        logic      w0;
        reg_addr_t a0;
        qword_t    d0;
        logic      w1;
        reg_addr_t a1;
        qword_t    d1;
    } stim_t;

    typedef struct packed {
        opcode_t   op;
        fmt_t      fmt;
        reg_addr_t rt;
        imm_t      imm;
        logic      rw;
        qword_t    ra, rb, rc;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb [$];

    function automatic exp_t nop_e();
        return '0;
    endfunction

    function automatic exp_t mk_e(opcode_t o, fmt_t f, reg_addr_t t,
                                  imm_t i, logic w,
                                  qword_t a, qword_t b, qword_t c);
        exp_t e;
        e.op = o; e.fmt = f; e.rt = t; e.imm = i; e.rw = w;
        e.ra = a; e.rb = b; e.rc = c;
        return e;
    endfunction

    function automatic stim_t mk_s(logic v, opcode_t o, fmt_t f,
                                   reg_addr_t a, reg_addr_t b,
                                   reg_addr_t c, reg_addr_t t,
                                   imm_t i, logic w);
        stim_t s;
        s = '{default: '0};
        s.valid = v; s.op = o; s.fmt = f;
        s.ra = a; s.rb = b; s.rc = c; s.rt = t;
        s.imm = i; s.rw = w;
        return s;
    endfunction

    task automatic clr();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_op = '0; in_format = '0;
        in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
        in_rt_addr = '0; in_imm = '0; in_reg_write = 1'b0;
        wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
        fwd_en = '0; fwd_addr = '0; fwd_data = '0;
    endtask

    task automatic drive(input stim_t s);
        in_valid = s.valid; in_op = s.op; in_format = s.fmt;
        in_ra_addr = s.ra; in_rb_addr = s.rb; in_rc_addr = s.rc;
        in_rt_addr = s.rt; in_imm = s.imm; in_reg_write = s.rw;
        wb0_en = s.w0; wb0_addr = s.a0; wb0_data = s.d0;
        wb1_en = s.w1; wb1_addr = s.a1; wb1_data = s.d1;
    endtask

    // Push expectation, clock once, then compare off the edge.
    task automatic cyc(input string name, input exp_t e);
        exp_t x;
        exp_t a;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        a = mk_e(op, format, rt_addr, imm, reg_write, ra, rb, rc);
        n_vec++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got op=%h fmt=%h rt=%h imm=%h rw=%b ra=%h rb=%h rc=%h want op=%h fmt=%h rt=%h imm=%h rw=%b ra=%h rb=%h rc=%h",
                     name, a.op, a.fmt, a.rt, a.imm, a.rw, a.ra, a.rb, a.rc,
                     x.op, x.fmt, x.rt, x.imm, x.rw, x.ra, x.rb, x.rc);
        end
    endtask

    vec_t vt [$];

    initial begin
        stim_t s;
        vec_t  v;

        // Reset held two cycles with junk inputs, stall and a writeback.
        clr();
        reset = 1'b0; stall = 1'b1;
        drive(mk_s(1'b1, 11'h7FF, 3'd5, 7'd5, 7'd6, 7'd7, 7'd8,
                   18'h3FFFF, 1'b1));
        wb0_en = 1'b1; wb0_addr = 7'd5; wb0_data = Q66;
        cyc("reset0", nop_e());
        cyc("reset1", nop_e());
        clr();
        drive(mk_s(1'b1, 11'h000, FMT_RR, 7'd5, 7'd6, 7'd7, 7'd0,
                   18'h0, 1'b0));
        cyc("read_after_reset", nop_e());

        // Vector table
        s = mk_s(1'b1, 11'h05F, FMT_RR, 7'd5, 7'd1, 7'd2, 7'd10,
                 18'h3FFFF, 1'b1);
        s.w0 = 1'b1; s.a0 = 7'd5; s.d0 = Q5;
        v.name = "write_through"; v.s = s;
        v.e = mk_e(11'h05F, FMT_RR, 7'd10, 18'h3FFFF, 1'b1, Q5, '0, '0);
        vt.push_back(v);

        s = mk_s(1'b1, 11'h001, FMT_RR, 7'd9, 7'd9, 7'd3, 7'd2,
                 18'h1, 1'b0);
        s.w0 = 1'b1; s.a0 = 7'd9; s.d0 = QAA;
        s.w1 = 1'b1; s.a1 = 7'd9; s.d1 = QBB;
        v.name = "collision_wt"; v.s = s;
        v.e = mk_e(11'h001, FMT_RR, 7'd2, 18'h1, 1'b0, QBB, QBB, '0);
        vt.push_back(v);

        s = mk_s(1'b1, 11'h002, FMT_RR, 7'd9, 7'd5, 7'd9, 7'd3,
                 18'h2, 1'b1);
        v.name = "collision_tbl"; v.s = s;
        v.e = mk_e(11'h002, FMT_RR, 7'd3, 18'h2, 1'b1, QBB, Q5, QBB);
        vt.push_back(v);

        s = mk_s(1'b1, 11'h404, FMT_RI7, 7'd0, 7'd1, 7'd5, 7'd4,
                 18'h0007F, 1'b1);
        s.w1 = 1'b1; s.a1 = 7'd0; s.d1 = QCC;
        s.w0 = 1'b1; s.a0 = 7'd1; s.d0 = QDD;
        v.name = "r0_ordinary"; v.s = s;
        v.e = mk_e(11'h404, FMT_RI7, 7'd4, 18'h0007F, 1'b1, QCC, QDD, Q5);
        vt.push_back(v);

        s = mk_s(1'b0, 11'h123, FMT_RI7, 7'd0, 7'd1, 7'd5, 7'd4,
                 18'h12345, 1'b1);
        v.name = "invalid_nop"; v.s = s; v.e = nop_e();
        vt.push_back(v);

        s = mk_s(1'b1, 11'h7FF, 3'd7, 7'd0, 7'd1, 7'd9, 7'd127,
                 18'h20000, 1'b0);
        v.name = "table_read"; v.s = s;
        v.e = mk_e(11'h7FF, 3'd7, 7'd127, 18'h20000, 1'b0, QCC, QDD, QBB);
        vt.push_back(v);

        s = mk_s(1'b1, 11'h010, FMT_RR, 7'd127, 7'd126, 7'd0, 7'd126,
                 18'h0, 1'b1);
        s.w0 = 1'b1; s.a0 = 7'd127; s.d0 = QEE;
        s.w1 = 1'b1; s.a1 = 7'd126; s.d1 = Q11;
        v.name = "top_regs"; v.s = s;
        v.e = mk_e(11'h010, FMT_RR, 7'd126, 18'h0, 1'b1, QEE, Q11, QCC);
        vt.push_back(v);

        s = mk_s(1'b1, 11'h011, FMT_RR, 7'd127, 7'd126, 7'd50, 7'd1,
                 18'h0, 1'b1);
        s.w0 = 1'b1; s.a0 = 7'd126; s.d0 = Q22;
        s.w1 = 1'b1; s.a1 = 7'd50; s.d1 = Q33;
        v.name = "wb_over_tbl"; v.s = s;
        v.e = mk_e(11'h011, FMT_RR, 7'd1, 18'h0, 1'b1, QEE, Q22, Q33);
        vt.push_back(v);

        for (int i = 0; i < vt.size(); i++) begin
            clr();
            drive(vt[i].s);
            cyc(vt[i].name, vt[i].e);
        end

`ifdef REGFILE_FWD_EN
        // Youngest matching tap beats older tap and writeback.
        clr();
        drive(mk_s(1'b1, 11'h020, FMT_RR, 7'd0, 7'd3, 7'd0, 7'd3,
                   18'h0, 1'b1));
        fwd_en[2] = 1'b1; fwd_addr[2] = 7'd3; fwd_data[2] = Q11;
        fwd_en[0] = 1'b1; fwd_addr[0] = 7'd3; fwd_data[0] = Q22;
        fwd_en[1] = 1'b1; fwd_addr[1] = 7'd4; fwd_data[1] = Q44;
        wb0_en = 1'b1; wb0_addr = 7'd3; wb0_data = Q33;
        cyc("fwd_tap0", mk_e(11'h020, FMT_RR, 7'd3, 18'h0, 1'b1,
                             QCC, Q22, QCC));
        fwd_en[0] = 1'b0; wb0_en = 1'b0;
        cyc("fwd_tap2", mk_e(11'h020, FMT_RR, 7'd3, 18'h0, 1'b1,
                             QCC, Q11, QCC));
        fwd_en = '0;
        cyc("fwd_none", mk_e(11'h020, FMT_RR, 7'd3, 18'h0, 1'b1,
                             QCC, Q33, QCC));
`endif

        // Stall holds A, ignores later writeback; flush then B.
        clr();
        drive(mk_s(1'b1, 11'h0A1, FMT_RR, 7'd5, 7'd9, 7'd0, 7'd12,
                   18'h00ABC, 1'b1));
        cyc("load_A", mk_e(11'h0A1, FMT_RR, 7'd12, 18'h00ABC, 1'b1,
                           Q5, QBB, QCC));
        drive(mk_s(1'b1, 11'h0B2, FMT_RI7, 7'd9, 7'd5, 7'd1, 7'd13,
                   18'h00DEF, 1'b0));
        stall = 1'b1;
        wb0_en = 1'b1; wb0_addr = 7'd5; wb0_data = Q44;
        for (int k = 0; k < 3; k++)
            cyc("stall_hold", mk_e(11'h0A1, FMT_RR, 7'd12, 18'h00ABC,
                                   1'b1, Q5, QBB, QCC));
        wb0_en = 1'b0;
        stall = 1'b0; flush = 1'b1;
        cyc("flush", nop_e());
        flush = 1'b0;
        cyc("load_B", mk_e(11'h0B2, FMT_RI7, 7'd13, 18'h00DEF, 1'b0,
                           QBB, Q44, QDD));

        // Reset mid-stream during stall beats stall, flush and write.
        clr();
        drive(mk_s(1'b1, 11'h0C3, FMT_RR, 7'd7, 7'd5, 7'd0, 7'd7,
                   18'h0, 1'b1));
        wb0_en = 1'b1; wb0_addr = 7'd7; wb0_data = Q55;
        cyc("load_r7", mk_e(11'h0C3, FMT_RR, 7'd7, 18'h0, 1'b1,
                            Q55, Q44, QCC));
        reset = 1'b0; stall = 1'b1; flush = 1'b1;
        wb0_data = Q66;
        cyc("reset_mid", nop_e());
        clr();
        drive(mk_s(1'b1, 11'h0C4, FMT_RR, 7'd7, 7'd5, 7'd9, 7'd0,
                   18'h1, 1'b0));
        cyc("r7_cleared", mk_e(11'h0C4, FMT_RR, 7'd0, 18'h1, 1'b0,
                               '0, '0, '0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
